// File: rtl/cpu_mem_responder.sv
// Memory-side responder: 64x16 IMEM filled by a byte-wide host loader, 64x16 DMEM for loads/stores.
// Optional macro DMEM_BYPASS_EN forwards same-cycle store data to a qualified DMEM read.
module cpu_mem_responder #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic [AW-1:0] rom_addr,
  input  logic          rom_en,
  output logic [DW-1:0] rom_data,
  input  logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_wdata,
  input  logic          ram_we,
  input  logic          ram_re,
  input  logic          ram_rd_en,
  output logic [DW-1:0] ram_rdata,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic [AW:0]   ld_count,
  output logic          cpu_hold
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StLoadHi, StLoadLo, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    hi_q, hi_d;
  logic          accept;
  logic          imem_we;
  logic          dmem_we;
  logic          rd_qual;

  logic [DW-1:0] imem [Depth];
  logic [DW-1:0] dmem [Depth];

  assign cpu_hold = (state_q != StRun);
  assign ld_ready = (state_q != StRun);
  assign ld_count = count_q;
  assign accept   = ld_valid && ld_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    hi_d    = hi_q;
    imem_we = 1'b0;
    // A restart wins over a same-cycle byte, which is dropped.
    if (ld_start) begin
      state_d = StLoadHi;
      ptr_d   = '0;
      count_d = '0;
    end else if (accept) begin
      case (state_q)
        StLoadHi: begin
          hi_d    = ld_byte;
          state_d = StLoadLo;
        end
        StLoadLo: begin
          imem_we = 1'b1;
          count_d = count_q + 1'b1;
          if (ld_last || (ptr_q == {AW{1'b1}})) begin
            state_d = StRun;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = StLoadHi;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_q <= StLoadHi;
      ptr_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      hi_q    <= hi_d;
    end
  end

  assign dmem_we = ram_we && !cpu_hold;

  // Memory arrays are intentionally not reset so a reset keeps the loaded program.
  always_ff @(posedge clk_main) begin
    if (imem_we) begin
      imem[ptr_q] <= DW'({hi_q, ld_byte});
    end
    if (dmem_we) begin
      dmem[ram_addr] <= ram_wdata;
    end
  end

  assign rom_data = (rom_en && !cpu_hold) ? imem[rom_addr] : '0;

  assign rd_qual = ram_re && ram_rd_en && !cpu_hold;

`ifdef DMEM_BYPASS_EN
  always_comb begin
    ram_rdata = '0;
    if (rd_qual) begin
      ram_rdata = ram_we ? ram_wdata : dmem[ram_addr];
    end
  end
`else
  assign ram_rdata = rd_qual ? dmem[ram_addr] : '0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios then randomized traffic
// checked against a word/byte-level reference model.
module tb_cpu_mem_responder;

  logic        clk_main = 1'b0;
  logic        reset;
  logic [5:0]  rom_addr;
  logic        rom_en;
  logic [15:0] rom_data;
  logic [5:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic        ram_rd_en;
  logic [15:0] ram_rdata;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic [6:0]  ld_count;
  logic        cpu_hold;

  cpu_mem_responder #(.AW(6), .DW(16)) dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rd_en (ram_rd_en),
    .ram_rdata (ram_rdata),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_count  (ld_count),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk_main = ~clk_main;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: program memory/data memory plus loader progress.
  logic [15:0] m_imem [64];
  bit          m_ik   [64];
  logic [15:0] m_dmem [64];
  bit          m_dk   [64];
  bit          m_loading;
  bit          m_have_hi;
  logic [7:0]  m_hi;
  int          m_ptr;
  int          m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_loading = 1'b1;
    m_have_hi = 1'b0;
    m_ptr     = 0;
    m_count   = 0;
  endtask

  task automatic m_edge();
    if (ram_we && !m_loading) begin
      m_dmem[ram_addr] = ram_wdata;
      m_dk[ram_addr]   = 1'b1;
    end
    if (ld_start) begin
      m_loading = 1'b1;
      m_have_hi = 1'b0;
      m_ptr     = 0;
      m_count   = 0;
    end else if (ld_valid && m_loading) begin
      if (!m_have_hi) begin
        m_hi      = ld_byte;
        m_have_hi = 1'b1;
      end else begin
        m_imem[m_ptr] = {m_hi, ld_byte};
        m_ik[m_ptr]   = 1'b1;
        m_count++;
        m_have_hi = 1'b0;
        if (ld_last || m_ptr == 63) m_loading = 1'b0;
        else m_ptr++;
      end
    end
  endtask

  task automatic check_outputs();
    bit qual;
    check_eq("ld_count", ld_count, m_count);
    check_eq("cpu_hold", cpu_hold, m_loading);
    check_eq("ld_ready", ld_ready, m_loading);
    if (rom_en && !m_loading) begin
      if (m_ik[rom_addr]) check_eq("rom_data", rom_data, m_imem[rom_addr]);
    end else begin
      check_eq("rom_zero", rom_data, 0);
    end
    qual = ram_re && ram_rd_en && !m_loading;
    if (!qual) begin
      check_eq("ram_zero", ram_rdata, 0);
    end else begin
`ifdef DMEM_BYPASS_EN
      if (ram_we) check_eq("ram_fwd", ram_rdata, ram_wdata);
      else if (m_dk[ram_addr]) check_eq("ram_rdata", ram_rdata, m_dmem[ram_addr]);
`else
      if (m_dk[ram_addr]) check_eq("ram_rdata", ram_rdata, m_dmem[ram_addr]);
`endif
    end
  endtask

  // Inputs are driven just after a falling edge; outputs are checked before the rising edge.
  task automatic tick();
    #2;
    check_outputs();
    @(posedge clk_main);
    m_edge();
    @(negedge clk_main);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    #1;
    check_eq("rst_count", ld_count, 0);
    check_eq("rst_hold", cpu_hold, 1);
    check_eq("rst_ready", ld_ready, 1);
    @(posedge clk_main);
    @(negedge clk_main);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic start);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    ld_start = start;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_start = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    rom_addr = '0; rom_en = 1'b0;
    ram_addr = '0; ram_wdata = '0; ram_we = 1'b0; ram_re = 1'b0; ram_rd_en = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    for (int i = 0; i < 64; i++) begin
      m_ik[i] = 1'b0;
      m_dk[i] = 1'b0;
    end
    @(negedge clk_main);
    do_reset();

    // Two-word program with ld_last on the final low byte.
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'hAB, 1'b0, 1'b0);
    check_eq("hold_before_last", cpu_hold, 1);
    send_byte(8'hCD, 1'b1, 1'b0);
    rom_en = 1'b1; rom_addr = 6'd1;
    #1;
    check_eq("rom1", rom_data, 16'hABCD);
    rom_addr = 6'd0;
    #1;
    check_eq("rom0", rom_data, 16'h1234);
    check_eq("count2", ld_count, 2);
    check_eq("hold_run", cpu_hold, 0);
    tick();

    // Full 64-word load ends on its own; further bytes are ignored.
    pulse_start();
    for (int i = 0; i < 128; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    #1;
    check_eq("count64", ld_count, 64);
    check_eq("ready_run", ld_ready, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rom_addr = 6'($urandom);
      tick();
    end

    // Store then read, qualified and unqualified.
    ram_we = 1'b1; ram_addr = 6'd5; ram_wdata = 16'hBEEF;
    tick();
    ram_we = 1'b0; ram_re = 1'b1; ram_rd_en = 1'b1;
    #1;
    check_eq("beef", ram_rdata, 16'hBEEF);
    ram_rd_en = 1'b0;
    #1;
    check_eq("no_rd_en", ram_rdata, 16'h0000);
    tick();

    // Same-cycle store and read of one address.
    ram_we = 1'b1; ram_re = 1'b0; ram_addr = 6'd9; ram_wdata = 16'h0001;
    tick();
    ram_wdata = 16'h5A5A; ram_re = 1'b1; ram_rd_en = 1'b1;
    #1;
`ifdef DMEM_BYPASS_EN
    check_eq("same_cycle", ram_rdata, 16'h5A5A);
`else
    check_eq("same_cycle", ram_rdata, 16'h0001);
`endif
    tick();
    ram_we = 1'b0;
    #1;
    check_eq("after_store", ram_rdata, 16'h5A5A);
    tick();
    ram_re = 1'b0; ram_rd_en = 1'b0;

    // Restart coincident with an accepted low byte discards that word.
    pulse_start();
    send_byte(8'h77, 1'b0, 1'b0);
    send_byte(8'h88, 1'b0, 1'b1);
    #1;
    check_eq("start_count", ld_count, 0);
    check_eq("start_hold", cpu_hold, 1);
    check_eq("start_ready", ld_ready, 1);
    send_byte(8'h99, 1'b0, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    rom_addr = 6'd0;
    #1;
    check_eq("restart_word", rom_data, 16'h9911);
    check_eq("restart_count", ld_count, 1);
    tick();

    // Reset between hi and lo bytes; a store during hold is dropped.
    pulse_start();
    send_byte(8'h42, 1'b0, 1'b0);
    do_reset();
    ram_we = 1'b1; ram_addr = 6'd5; ram_wdata = 16'hDEAD;
    tick();
    ram_we = 1'b0;
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    ram_re = 1'b1; ram_rd_en = 1'b1; ram_addr = 6'd5;
    #1;
    check_eq("hold_store_dropped", ram_rdata, 16'hBEEF);
    check_eq("reload_count", ld_count, 1);
    tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_byte   = 8'($urandom);
      ld_last   = ($urandom_range(0, 7) == 0);
      ld_start  = ($urandom_range(0, 63) == 0);
      rom_en    = ($urandom_range(0, 3) != 0);
      rom_addr  = 6'($urandom);
      ram_addr  = 6'($urandom_range(0, 7));
      ram_wdata = 16'($urandom);
      ram_we    = ($urandom_range(0, 2) == 0);
      ram_re    = ($urandom_range(0, 1) == 0);
      ram_rd_en = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
